lose_beeper: RTL and testbench

LOSE_BEEPER -- requirements
Module: lose_beeper

---
 rtl/lose_beeper.sv | 201 ++++++++++++++++++++
 tb/tb_lose_beeper.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lose_beeper.sv
// -----------------------------------------------------------------------------
// lose_beeper
//
// Plays the "lose count" as a series of audible beeps. When a start request is
// accepted in IDLE, the block sounds count_eff beeps (count clamped to 9), each
// BEEP_LEN cycles long and separated by GAP_LEN silent cycles. During a beep
// the speaker is driven with a square wave that toggles every HALF_PERIOD
// cycles. A one-cycle done pulse marks normal completion; abort or reset
// terminates playback silently, with no done pulse.
//
// Parameters
//   BEEP_LEN    - clock cycles per beep            (2 .. 2^26-1)
//   GAP_LEN     - silent cycles between two beeps  (1 .. 2^26-1)
//   HALF_PERIOD - clock cycles per audio half-wave (1 .. 2^20-1)
//
// Ports
//   clk        in   single clock, rising-edge active
//   rst        in   synchronous, active-high reset
//   start      in   playback request, honoured only in IDLE without abort
//   count      in   lose count 0..9 (larger values clamp to 9), sampled on accept
//   abort      in   stop playback immediately, no done pulse
//   audio      out  square-wave speaker drive, 0 outside BEEP
//   busy       out  high while in BEEP or GAP
//   done       out  one-cycle pulse on normal completion
//   beeps_left out  beeps remaining, including the one currently sounding
//
// All outputs are registered: each has a _d value computed from the next state
// and is captured together with the state register.
// -----------------------------------------------------------------------------
module lose_beeper #(
  parameter int BEEP_LEN    = 25_000_000,
  parameter int GAP_LEN     = 25_000_000,
  parameter int HALF_PERIOD = 113_636
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       abort,
  output logic       audio,
  output logic       busy,
  output logic       done,
  output logic [3:0] beeps_left
);

  // Timer widths cover the full legal parameter ranges, so the terminal
  // compare values below are always reachable without wrap-around.
  localparam int BEAT_W = 26;
  localparam int TONE_W = 20;

  // Timers count 0 .. LEN-1; the terminal value marks the last cycle of a phase.
  localparam logic [BEAT_W-1:0] BEEP_LAST = BEAT_W'(BEEP_LEN - 1);
  localparam logic [BEAT_W-1:0] GAP_LAST  = BEAT_W'(GAP_LEN - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(HALF_PERIOD - 1);

  localparam logic [3:0] COUNT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q,      state_d;
  logic [BEAT_W-1:0] beat_q,       beat_d;
  logic [TONE_W-1:0] tone_q,       tone_d;
  logic              audio_q,      audio_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic [3:0]        beeps_left_q, beeps_left_d;

  logic [3:0]        count_eff;

  // The lose counter should never exceed 9, but clamp defensively so a glitchy
  // upstream value cannot request more than nine beeps.
  assign count_eff = (count > COUNT_MAX) ? COUNT_MAX : count;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    beat_d       = beat_q;
    tone_d       = tone_q;
    audio_d      = 1'b0;
    beeps_left_d = beeps_left_q;

    unique case (state_q)
      IDLE: begin
        beat_d       = '0;
        tone_d       = '0;
        beeps_left_d = '0;
        // abort wins over a simultaneous start: the request is dropped.
        if (start && !abort) begin
          if (count_eff != 4'd0) begin
            state_d      = BEEP;
            beeps_left_d = count_eff;
          end else begin
            state_d = DONE;
          end
        end
      end

      BEEP: begin
        if (abort) begin
          state_d      = IDLE;
          beat_d       = '0;
          tone_d       = '0;
          beeps_left_d = '0;
        end else if (beat_q == BEEP_LAST) begin
          // Last beep cycle: audio is forced low on the way out (default 0).
          beat_d       = '0;
          tone_d       = '0;
          beeps_left_d = beeps_left_q - 4'd1;
          state_d      = (beeps_left_q == 4'd1) ? DONE : GAP;
        end else begin
          beat_d = beat_q + 1'b1;
          if (tone_q == TONE_LAST) begin
            tone_d  = '0;
            audio_d = ~audio_q;
          end else begin
            tone_d  = tone_q + 1'b1;
            audio_d = audio_q;
          end
        end
      end

      GAP: begin
        if (abort) begin
          state_d      = IDLE;
          beat_d       = '0;
          tone_d       = '0;
          beeps_left_d = '0;
        end else if (beat_q == GAP_LAST) begin
          // Next beep starts with both timers cleared, so its waveform is
          // identical to the first one.
          state_d = BEEP;
          beat_d  = '0;
          tone_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      DONE: begin
        // DONE always lasts exactly one cycle; abort here leads to the same
        // place, so it needs no separate branch.
        state_d      = IDLE;
        beat_d       = '0;
        tone_d       = '0;
        beeps_left_d = '0;
      end

      default: begin
        state_d      = IDLE;
        beat_d       = '0;
        tone_d       = '0;
        beeps_left_d = '0;
      end
    endcase

    // Status outputs follow the next state so they are valid in the same cycle
    // as the state they describe.
    busy_d = (state_d == BEEP) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers (synchronous reset has priority over all inputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      tone_q       <= '0;
      audio_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      beeps_left_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      tone_q       <= tone_d;
      audio_q      <= audio_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      beeps_left_q <= beeps_left_d;
    end
  end

  assign audio      = audio_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign beeps_left = beeps_left_q;

endmodule

// File: tb/tb_lose_beeper.sv
// -----------------------------------------------------------------------------
// tb_lose_beeper
//
// Directed self-checking bench for lose_beeper with BEEP_LEN=8, GAP_LEN=4,
// HALF_PERIOD=2. Inputs change 1 time unit after a rising edge and outputs are
// sampled at the same point, so each sample shows the state after that edge.
// Sample index 0 is the cycle right after the edge that accepted start.
// -----------------------------------------------------------------------------
module tb_lose_beeper;

  localparam int BL = 8;
  localparam int GL = 4;
  localparam int HP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] count;
  logic       abort;
  logic       audio;
  logic       busy;
  logic       done;
  logic [3:0] beeps_left;

  int tests_run = 0;
  int tests_failed = 0;

  lose_beeper #(
    .BEEP_LEN   (BL),
    .GAP_LEN    (GL),
    .HALF_PERIOD(HP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .abort     (abort),
    .audio     (audio),
    .busy      (busy),
    .done      (done),
    .beeps_left(beeps_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a playback and follows it sample by sample against a reference
  // waveform: beep/gap slots of BL+GL cycles, audio high on the 2nd half-period
  // of every HP*2 window inside a beep, beeps_left dropping after each beep.
  // restart_idx >= 0 pulses a second start (count=9) after that sample.
  task automatic run_play(input logic [3:0] cnt, input int n_eff,
                          input int restart_idx, input string name);
    int total;
    int busy_cnt;
    int done_idx;
    int done_cnt;
    int aud_err;
    int bl_err;
    int p;
    int slot;
    logic       exp_audio;
    logic [3:0] exp_bl;
    total    = n_eff * BL + (n_eff - 1) * GL;
    busy_cnt = 0;
    done_idx = -1;
    done_cnt = 0;
    aud_err  = 0;
    bl_err   = 0;
    start = 1'b1;
    count = cnt;
    tick();
    start = 1'b0;
    for (int i = 0; i < total + 4; i++) begin
      if (i < total) begin
        slot = i / (BL + GL);
        p    = i % (BL + GL);
        if (p < BL) begin
          exp_audio = ((p / HP) % 2) == 1;
          exp_bl    = 4'(n_eff - slot);
        end else begin
          exp_audio = 1'b0;
          exp_bl    = 4'(n_eff - slot - 1);
        end
      end else begin
        exp_audio = 1'b0;
        exp_bl    = 4'd0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (audio !== exp_audio) aud_err++;
      if (beeps_left !== exp_bl) bl_err++;
      if (i == restart_idx) begin
        start = 1'b1;
        count = 4'd9;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;

    tests_run++;
    if (busy_cnt !== total) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, total);
    end
    tests_run++;
    if (done_idx !== total) begin
      tests_failed++;
      $display("FAIL %s done_index: got %0d expected %0d", name, done_idx, total);
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    tests_run++;
    if (aud_err !== 0) begin
      tests_failed++;
      $display("FAIL %s audio_pattern: got %0d bad samples expected 0", name, aud_err);
    end
    tests_run++;
    if (bl_err !== 0) begin
      tests_failed++;
      $display("FAIL %s beeps_left_seq: got %0d bad samples expected 0", name, bl_err);
    end
  endtask

  // Checks all four outputs against one expected set of values.
  task automatic check_outputs(input string name, input logic e_audio,
                               input logic e_busy, input logic e_done,
                               input logic [3:0] e_bl);
    tests_run++;
    if ({audio, busy, done, beeps_left} !== {e_audio, e_busy, e_done, e_bl}) begin
      tests_failed++;
      $display("FAIL %s: got audio=%b busy=%b done=%b beeps_left=%0d expected audio=%b busy=%b done=%b beeps_left=%0d",
               name, audio, busy, done, beeps_left, e_audio, e_busy, e_done, e_bl);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    count = 4'd0;
    abort = 1'b0;
    tick();
    tick();
    check_outputs("reset_state", 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick();
    check_outputs("idle_after_reset", 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_count3();
    run_play(4'd3, 3, -1, "count3");
  endtask

  task automatic test_count0();
    int busy_seen;
    start = 1'b1;
    count = 4'd0;
    tick();
    start = 1'b0;
    check_outputs("count0_done", 1'b0, 1'b0, 1'b1, 4'd0);
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy || audio || done) busy_seen++;
    end
    tests_run++;
    if (busy_seen !== 0) begin
      tests_failed++;
      $display("FAIL count0_quiet_after: got %0d active samples expected 0", busy_seen);
    end
  endtask

  task automatic test_count15();
    run_play(4'd15, 9, -1, "count15_clamp");
  endtask

  task automatic test_abort();
    int active;
    start = 1'b1;
    count = 4'd5;
    tick();
    start = 1'b0;
    // idx 20..23 is the second gap; step to idx 21.
    for (int i = 0; i < 21; i++) tick();
    check_outputs("abort_in_gap2_before", 1'b0, 1'b1, 1'b0, 4'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_outputs("abort_result", 1'b0, 1'b0, 1'b0, 4'd0);
    active = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || audio || done || (beeps_left != 4'd0)) active++;
    end
    tests_run++;
    if (active !== 0) begin
      tests_failed++;
      $display("FAIL abort_stays_idle: got %0d active samples expected 0", active);
    end
  endtask

  task automatic test_ignored_start();
    int active;
    // Second start during the first beep must not add beeps or restart.
    run_play(4'd2, 2, 3, "start_in_beep");
    // start together with abort in IDLE is rejected.
    start = 1'b1;
    abort = 1'b1;
    count = 4'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_outputs("start_abort_idle", 1'b0, 1'b0, 1'b0, 4'd0);
    active = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy || audio || done) active++;
    end
    tests_run++;
    if (active !== 0) begin
      tests_failed++;
      $display("FAIL start_abort_quiet: got %0d active samples expected 0", active);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    count = 4'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    // idx 3 is inside the first beep with audio high.
    check_outputs("pre_reset_beep", 1'b1, 1'b1, 1'b0, 4'd4);
    rst = 1'b1;
    tick();
    check_outputs("reset_mid_play", 1'b0, 1'b0, 1'b0, 4'd0);
    // Start is presented on the very first edge with rst low.
    rst = 1'b0;
    run_play(4'd1, 1, -1, "after_reset_count1");
  endtask

  initial begin
    test_reset();
    test_count3();
    test_count0();
    test_count15();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time limit so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
